// File: rtl/dac_frame_arbiter.sv
// Round-robin arbiter that shares one SPI dual-DAC link between two sample producers.
// Optional macro DAC_FRAME_ARBITER_LDAC_EN adds a spi_ldac_n strobe after each ch0+ch1 frame pair.
module dac_frame_arbiter #(
  parameter int   SPI_DIV  = 8,
  parameter int   CS_IDLE  = 4,
  parameter logic BUF_BIT  = 1'b0,
  parameter logic GA_N_BIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [11:0] req_data0,
  input  logic [11:0] req_data1,
  output logic [1:0]  req_ready,
  output logic        busy,
  output logic        last_ch,
`ifdef DAC_FRAME_ARBITER_LDAC_EN
  output logic        spi_ldac_n,
`endif
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

`ifdef DAC_FRAME_ARBITER_LDAC_EN
  localparam int GAP_LEN = (CS_IDLE > SPI_DIV) ? CS_IDLE : SPI_DIV;
`else
  localparam int GAP_LEN = CS_IDLE;
`endif
  localparam int DIV_W = $clog2(SPI_DIV + 1);
  localparam int GAP_W = $clog2(GAP_LEN + 1);

  logic [1:0]       state;
  logic [15:0]      frame;
  logic [3:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant;
  logic             capture;
  logic             div_done;
  logic             frame_done;

  // Contested requests go to the channel that was not served last.
  always_comb begin
    grant     = (req_valid == 2'b11) ? ~last_ch : req_valid[1];
    req_ready = 2'b00;
    if (state == ST_IDLE && req_valid != 2'b00)
      req_ready = grant ? 2'b10 : 2'b01;
    capture    = |(req_valid & req_ready);
    div_done   = (div_cnt == DIV_W'(SPI_DIV - 1));
    frame_done = (state == ST_SHIFT) && div_done && spi_sck && (bit_cnt == 4'd15);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      last_ch  <= 1'b1;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            frame    <= {grant, BUF_BIT, GA_N_BIT, 1'b1, grant ? req_data1 : req_data0};
            last_ch  <= grant;
            spi_cs_n <= 1'b0;
            spi_mosi <= grant;
            spi_sck  <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (div_done) begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              // Data only moves on the falling edge so the DAC sees it stable while sck is high.
              spi_sck <= 1'b0;
              if (bit_cnt == 4'd15) begin
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                gap_cnt  <= '0;
                state    <= ST_GAP;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                spi_mosi <= frame[14];
                frame    <= {frame[14:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_LEN - 1)) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DAC_FRAME_ARBITER_LDAC_EN
  logic             ch0_seen;
  logic [DIV_W-1:0] ldac_cnt;

  // Strobe only once a ch1 frame completes a pair that includes a fresh ch0 update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_ldac_n <= 1'b1;
      ch0_seen   <= 1'b0;
      ldac_cnt   <= '0;
    end else begin
      if (state == ST_IDLE && capture && !grant)
        ch0_seen <= 1'b1;
      if (frame_done && last_ch && ch0_seen) begin
        spi_ldac_n <= 1'b0;
        ldac_cnt   <= '0;
        ch0_seen   <= 1'b0;
      end else if (!spi_ldac_n) begin
        if (ldac_cnt == DIV_W'(SPI_DIV - 1))
          spi_ldac_n <= 1'b1;
        else
          ldac_cnt <= ldac_cnt + DIV_W'(1);
      end
    end
  end
`endif

endmodule
